// File: rtl/mem_responder_if.sv
// mem_responder_if
//   Byte-wide request/response bus between the execution unit (master)
//   and the memory responder (slave).
//   address  : request address, sampled on acceptance
//   out_en   : read request
//   write_en : write request
//   wr_data  : write data, sampled on acceptance
//   rd_data  : read response data (holds until the next response)
//   rd_valid : one-cycle pulse marking a fresh read response
//   busy     : responder is inserting wait states; requests are ignored
//   err      : one-cycle pulse after a cycle that requested read and write together
interface mem_responder_if #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8
);
    logic [ADDR_BITS-1:0] address;
    logic                 out_en;
    logic                 write_en;
    logic [DATA_BITS-1:0] wr_data;
    logic [DATA_BITS-1:0] rd_data;
    logic                 rd_valid;
    logic                 busy;
    logic                 err;

    modport master (
        output address, out_en, write_en, wr_data,
        input  rd_data, rd_valid, busy, err
    );

    modport slave (
        input  address, out_en, write_en, wr_data,
        output rd_data, rd_valid, busy, err
    );
endinterface

// File: rtl/mem_responder.sv
// mem_responder
//   Memory-side responder for the byte-wide fetch/load/store bus. Serves
//   single-byte reads from a 2^ADDR_BITS x DATA_BITS array after
//   WAIT_STATES extra cycles and commits writes in one cycle.
//   clk   : system clock, all state changes on posedge
//   reset : synchronous active-high reset (array contents are preserved)
//   bus   : mem_responder_if slave modport (request in, response out)
module mem_responder #(
    parameter int ADDR_BITS   = 8,
    parameter int DATA_BITS   = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_responder_if.slave        bus
);
    typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_t;

    localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t               state;
    logic [3:0]           cnt;
    logic [ADDR_BITS-1:0] lat_addr;
    logic [DATA_BITS-1:0] mem [2**ADDR_BITS];
    logic                 accept;

    // Requests are only looked at while not inserting wait states.
    always_comb begin
        accept = (state != WAIT);
    end

    // Storage has no reset so contents survive a reset pulse. Reads below
    // sample mem with the pre-edge value, giving read-before-write.
    always_ff @(posedge clk) begin
        if (!reset && accept && bus.write_en) begin
            mem[bus.address] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            lat_addr     <= '0;
            bus.rd_data  <= '0;
            bus.rd_valid <= 1'b0;
            bus.busy     <= 1'b0;
            bus.err      <= 1'b0;
        end else begin
            bus.rd_valid <= 1'b0;
            bus.err      <= 1'b0;
            case (state)
                IDLE, RESPOND: begin
                    state <= IDLE;
                    if (bus.write_en) begin
                        // Write wins over a simultaneous read; flag the clash.
                        bus.err <= bus.out_en;
                    end else if (bus.out_en) begin
                        lat_addr <= bus.address;
                        if (WAIT_STATES == 0) begin
                            state        <= RESPOND;
                            bus.rd_data  <= mem[bus.address];
                            bus.rd_valid <= 1'b1;
                        end else begin
                            state    <= WAIT;
                            cnt      <= CNT_LOAD;
                            bus.busy <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state        <= RESPOND;
                        bus.rd_data  <= mem[lat_addr];
                        bus.rd_valid <= 1'b1;
                        bus.busy     <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
//   Directed bench for mem_responder. Three instances cover WAIT_STATES of
//   0, 2 and 3; each has its own bus so memories and timing are independent.
module tb_mem_responder;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mem_responder_if #(.ADDR_BITS(8), .DATA_BITS(8)) b0 ();
    mem_responder_if #(.ADDR_BITS(8), .DATA_BITS(8)) b2 ();
    mem_responder_if #(.ADDR_BITS(8), .DATA_BITS(8)) b3 ();

    mem_responder #(.ADDR_BITS(8), .DATA_BITS(8), .WAIT_STATES(0)) dut0 (.clk(clk), .reset(reset), .bus(b0));
    mem_responder #(.ADDR_BITS(8), .DATA_BITS(8), .WAIT_STATES(2)) dut2 (.clk(clk), .reset(reset), .bus(b2));
    mem_responder #(.ADDR_BITS(8), .DATA_BITS(8), .WAIT_STATES(3)) dut3 (.clk(clk), .reset(reset), .bus(b3));

    // Advance one edge; inputs change and outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr0(input logic [7:0] a, input logic [7:0] d);
        b0.address = a; b0.wr_data = d; b0.write_en = 1'b1; b0.out_en = 1'b0;
        tick();
        b0.write_en = 1'b0;
    endtask

    initial begin
        b0.address = '0; b0.out_en = 1'b0; b0.write_en = 1'b0; b0.wr_data = '0;
        b2.address = '0; b2.out_en = 1'b0; b2.write_en = 1'b0; b2.wr_data = '0;
        b3.address = '0; b3.out_en = 1'b0; b3.write_en = 1'b0; b3.wr_data = '0;

        // Reset state
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("rst0_outs", {b0.rd_data, 5'd0, b0.rd_valid, b0.busy, b0.err}, 16'h0000);
        check("rst2_outs", {b2.rd_data, 5'd0, b2.rd_valid, b2.busy, b2.err}, 16'h0000);
        check("rst3_outs", {b3.rd_data, 5'd0, b3.rd_valid, b3.busy, b3.err}, 16'h0000);

        // WS=0: write then immediate read
        wr0(8'h10, 8'h3C);
        check("ws0_wr_novalid", b0.rd_valid, 1'b0);
        b0.address = 8'h10; b0.out_en = 1'b1;
        tick();
        b0.out_en = 1'b0;
        check("ws0_rd_valid", b0.rd_valid, 1'b1);
        check("ws0_rd_data", b0.rd_data, 8'h3C);
        check("ws0_busy", b0.busy, 1'b0);
        tick();
        check("ws0_valid_drop", b0.rd_valid, 1'b0);

        // WS=0: back-to-back reads, one response per cycle
        for (int i = 0; i < 4; i++) wr0(8'(i), 8'hA0 + 8'(i));
        b0.out_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b0.address = 8'(i);
            tick();
            check("b2b_valid", b0.rd_valid, 1'b1);
            check("b2b_data", b0.rd_data, 8'hA0 + 8'(i));
            check("b2b_busy", b0.busy, 1'b0);
        end
        b0.out_en = 1'b0;
        tick();
        check("b2b_end_valid", b0.rd_valid, 1'b0);

        // WS=0: simultaneous read and write
        b0.address = 8'h20; b0.wr_data = 8'h55; b0.write_en = 1'b1; b0.out_en = 1'b1;
        tick();
        b0.write_en = 1'b0; b0.out_en = 1'b0;
        check("clash_err", b0.err, 1'b1);
        check("clash_novalid", b0.rd_valid, 1'b0);
        tick();
        check("clash_err_drop", b0.err, 1'b0);
        b0.address = 8'h20; b0.out_en = 1'b1;
        tick();
        b0.out_en = 1'b0;
        check("clash_rd_valid", b0.rd_valid, 1'b1);
        check("clash_rd_data", b0.rd_data, 8'h55);
        check("clash_rd_noerr", b0.err, 1'b0);

        // WS=0: rd_data holds after the pulse
        wr0(8'h01, 8'h9E);
        b0.address = 8'h01; b0.out_en = 1'b1;
        tick();
        b0.out_en = 1'b0;
        check("hold_first", b0.rd_data, 8'h9E);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_valid", b0.rd_valid, 1'b0);
            check("hold_data", b0.rd_data, 8'h9E);
        end

        // WS=2: wait states and a dropped write while busy
        b2.address = 8'h05; b2.wr_data = 8'h77; b2.write_en = 1'b1;
        tick();
        b2.write_en = 1'b0;
        b2.out_en = 1'b1;
        tick();
        b2.out_en = 1'b0;
        check("ws2_busy1", {b2.busy, b2.rd_valid}, 2'b10);
        b2.wr_data = 8'h11; b2.write_en = 1'b1;
        tick();
        b2.write_en = 1'b0;
        check("ws2_busy2", {b2.busy, b2.rd_valid}, 2'b10);
        tick();
        check("ws2_resp", {b2.busy, b2.rd_valid}, 2'b01);
        check("ws2_data", b2.rd_data, 8'h77);
        tick();
        check("ws2_idle", {b2.busy, b2.rd_valid}, 2'b00);
        b2.out_en = 1'b1;
        tick();
        b2.out_en = 1'b0;
        tick();
        tick();
        check("ws2_reread_valid", b2.rd_valid, 1'b1);
        check("ws2_dropped_wr", b2.rd_data, 8'h77);

        // WS=3: reset in the middle of a wait
        b3.address = 8'h20; b3.wr_data = 8'h55; b3.write_en = 1'b1;
        tick();
        b3.write_en = 1'b0;
        b3.out_en = 1'b1;
        tick();
        b3.out_en = 1'b0;
        check("ws3_busy", b3.busy, 1'b1);
        tick();
        reset = 1'b1; b3.out_en = 1'b1;
        tick();
        reset = 1'b0; b3.out_en = 1'b0;
        check("ws3_rst_outs", {b3.rd_data, 5'd0, b3.rd_valid, b3.busy, b3.err}, 16'h0000);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("ws3_post_rst", {b3.rd_valid, b3.busy}, 2'b00);
        end
        b3.out_en = 1'b1;
        tick();
        b3.out_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("ws3_wait", {b3.busy, b3.rd_valid}, 2'b10);
        end
        tick();
        check("ws3_resp", {b3.busy, b3.rd_valid}, 2'b01);
        check("ws3_kept", b3.rd_data, 8'h55);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the byte-wide fetch/load/store bus driven by the execution unit. Accepts single-byte read and write requests, serves reads from an internal 2^ADDR_BITS x DATA_BITS array after a programmable number of wait states, and commits writes in one cycle. Sits between the execution unit's memory port and the program/data storage, replacing the bare RAM model so fetch timing and stall behaviour are explicit and verifiable.

## Interface
Parameters:
- ADDR_BITS, 8, address width; storage depth is 2^ADDR_BITS bytes
- DATA_BITS, 8, data width
- WAIT_STATES, 0, extra cycles inserted between read acceptance and response (0..15)

Ports:
- clk  input  1  system clock; all state changes on posedge
- reset  input  1  synchronous, active-high reset (one clock; reset is synchronous and active-high)
- address  input  ADDR_BITS  request address, sampled on acceptance
- out_en  input  1  read request
- write_en  input  1  write request
- wr_data  input  DATA_BITS  write data, sampled on acceptance
- rd_data  output  DATA_BITS  read response data
- rd_valid  output  1  one-cycle pulse: rd_data holds response for the last accepted read
- busy  output  1  high while in WAIT; requests are ignored
- err  output  1  one-cycle pulse: out_en and write_en both high on an accepted cycle

## Operation
- States: IDLE, WAIT, RESPOND. Reset -> IDLE.
- Request accepted on a posedge when state is IDLE or RESPOND (busy=0). Requests while busy=1 are dropped, no side effects.
- Accepted write (write_en=1, out_en=0): mem[address] <= wr_data at that edge. State -> IDLE (or stays IDLE). No rd_valid.
- Accepted read (out_en=1, write_en=0): latch address. If WAIT_STATES=0 -> RESPOND at the same edge, rd_data <= mem[address]. Else -> WAIT, counter loaded with WAIT_STATES-1.
- WAIT: counter decrements each edge; at counter=0 -> RESPOND, rd_data <= mem[latched address].
- RESPOND: rd_valid=1 for this cycle. Next edge: new accepted read/write handled as above, otherwise -> IDLE. Back-to-back reads with WAIT_STATES=0 give one response per cycle.
- Both out_en and write_en high on an accepted cycle: write performed, read dropped, err=1 next cycle for one cycle.
- rd_data holds its last value until the next response; it is not cleared when rd_valid falls.
- Read data is the array value before any write committing at the same edge (read-before-write).
- Storage array is not cleared by reset; contents are preserved across reset.
- address beyond depth impossible by width; no wrap logic needed.

## Timing
- Reset values: rd_data=0, rd_valid=0, busy=0, err=0, state=IDLE, counter=0, latched address=0.
- Reset mid-read (in WAIT or RESPOND): pending read discarded, no rd_valid after reset; request present in the reset cycle is ignored.
- Read latency: request accepted at edge N -> rd_valid high in cycle after edge N+WAIT_STATES.
- busy high exactly WAIT_STATES cycles per accepted read (0 when WAIT_STATES=0).
- Write latency: visible to a read accepted at the following edge.
- out_en/write_en are level-sampled; holding out_en high issues a new read on every accepting edge.

## Test plan
- WAIT_STATES=0: write 0x3C to addr 0x10, then out_en at addr 0x10 -> rd_valid pulse next cycle, rd_data=0x3C, busy never high.
- WAIT_STATES=0, out_en held 4 cycles on addrs 0,1,2,3 preloaded 0xA0..0xA3 -> rd_valid high 4 consecutive cycles, rd_data 0xA0,0xA1,0xA2,0xA3.
- WAIT_STATES=2: read addr 0x05 (=0x77) -> busy high 2 cycles, rd_valid on third cycle with 0x77; a write to 0x05 of 0x11 issued while busy is dropped, later read returns 0x77.
- Simultaneous out_en and write_en at addr 0x20 with wr_data 0x55 -> no rd_valid, err pulse one cycle, subsequent read of 0x20 returns 0x55.
- WAIT_STATES=3: reset asserted one cycle mid-WAIT -> all outputs 0, no rd_valid afterward, array contents (e.g. 0x20=0x55) still readable after reset.
- rd_data hold: read 0x01 (=0x9E), then 3 idle cycles -> rd_valid low, rd_data stays 0x9E.
